// File: rtl/dm_pkg.sv
// Shared encodings for the multi-cycle MEM-stage data memory.
package dm_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_RANGE    = 2'b10
  } exc_e;

  typedef enum logic {IDLE, WAIT} state_e;

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension,
// and the alignment check for the requested access size.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    byte_en    = 4'b0000;
    wdata_rep  = wdata;
    load_ext   = rword;
    misaligned = 1'b0;
    lane_b     = rword[{addr, 3'b000} +: 8];
    lane_h     = rword[{addr[1], 4'b0000} +: 16];
    unique case (op_e'(op))
      OP_LW:  misaligned = (addr != 2'b00);
      OP_LH: begin
        misaligned = addr[0];
        load_ext   = {{16{lane_h[15]}}, lane_h};
      end
      OP_LHU: begin
        misaligned = addr[0];
        load_ext   = {16'h0000, lane_h};
      end
      OP_LB:  load_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU: load_ext = {24'h000000, lane_b};
      OP_SW: begin
        misaligned = (addr != 2'b00);
        byte_en    = 4'b1111;
      end
      OP_SH: begin
        misaligned = addr[0];
        byte_en    = 4'b0011 << {addr[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
      end
      OP_SB: begin
        byte_en   = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_pipe_mem.sv
// Multi-cycle data memory: valid/ready request port, range/alignment faults, byte-lane
// stores committed at accept, and a response strobe LATENCY cycles after accept.
module dm_pipe_mem
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH     = 3072,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter bit          TRACE     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc
);

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_e      state;
  logic [2:0]  cnt;
  logic [31:0] hold_rdata;
  logic [1:0]  hold_exc;

  logic        accept, in_range, store, do_write;
  logic [31:0] off, rword, merged, wmask, wdata_rep, load_ext;
  logic [IW-1:0] idx;
  logic [3:0]  byte_en;
  logic        misaligned;
  exc_e        exc_now;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign off       = req_addr - BASE_ADDR;
  assign in_range  = (req_addr >= BASE_ADDR) && (off < SPAN);
  assign idx       = off[IW+1:2];
  assign rword     = in_range ? mem[idx] : 32'h0;
  assign store     = is_store(op_e'(req_op));

  dm_lane_align u_align (
    .op        (req_op),
    .addr      (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .load_ext  (load_ext),
    .misaligned(misaligned)
  );

  // Range faults take priority over alignment faults.
  assign exc_now  = !in_range ? EXC_RANGE : (misaligned ? EXC_MISALIGN : EXC_NONE);
  assign wmask    = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
  assign merged   = (rword & ~wmask) | (wdata_rep & wmask);
  assign do_write = accept && store && (exc_now == EXC_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (do_write) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      hold_rdata <= 32'h0;
      hold_exc   <= EXC_NONE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_exc   <= EXC_NONE;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_exc   <= EXC_NONE;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= CNT_INIT;
            // Load data is captured now so later stores cannot disturb it.
            hold_rdata <= (store || (exc_now != EXC_NONE)) ? 32'h0 : load_ext;
            hold_exc   <= exc_now;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= hold_rdata;
            resp_exc   <= hold_exc;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (TRACE && !reset && do_write) begin
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_pipe_mem.sv
// Scoreboard bench: two instances (LATENCY=1 at base 0, LATENCY=4 at base 0x1000).
module tb_dm_pipe_mem;
  import dm_pkg::*;

  localparam int unsigned LAT0  = 1;
  localparam int unsigned LAT1  = 4;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [2:0]  req_op    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] req_pc    [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic [1:0]  resp_exc  [2];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc [2];
  bit   prev_hold[2];
  exp_t q0[$];
  exp_t q1[$];

  dm_pipe_mem #(.DEPTH(3072), .BASE_ADDR(32'h0), .LATENCY(LAT0), .TRACE(1'b1)) u_l1 (
    .clk(clk), .reset(reset0),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_exc(resp_exc[0])
  );

  dm_pipe_mem #(.DEPTH(3072), .BASE_ADDR(BASE1), .LATENCY(LAT1), .TRACE(1'b0)) u_l4 (
    .clk(clk), .reset(reset1),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_exc(resp_exc[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pop and compare every response strobe; outside a strobe rdata must read zero.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resp_valid[d] === 1'b1) begin
        exp_t e;
        bit   has;
        has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!has) begin
          check_eq("unexpected_resp", 32'(resp_valid[d]), 32'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check_eq("rdata", resp_rdata[d], e.rdata);
          check_eq("exc", 32'(resp_exc[d]), 32'(e.exc));
          check_eq("latency", 32'(cyc - e.acc), (d == 0) ? 32'(LAT0) : 32'(LAT1));
        end
      end else begin
        check_eq("idle_rdata", resp_rdata[d], 32'h0);
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic [1:0] exp_exc, input bit hold);
    exp_t e;
    bit   got;
    int   lat;
    lat = (d == 0) ? int'(LAT0) : int'(LAT1);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_pc[d]    = 32'h0000_0400 + 32'(cyc * 4);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (req_ready[d]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check_eq("accept_timeout", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    e.rdata = exp_rdata;
    e.exc   = exp_exc;
    e.acc   = cyc + 1;
    if (hold && prev_hold[d]) check_eq("accept_gap", 32'(e.acc - last_acc[d]), 32'(lat + 1));
    last_acc[d]  = e.acc;
    prev_hold[d] = hold;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid[d] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_eq("ready_busy", 32'(req_ready[d]), 32'd0);
    end
  endtask

  task automatic drain(input int d);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b0;
    prev_hold[d] = 1'b0;
    n = (d == 0) ? q0.size() : q1.size();
    for (int i = 0; i < 20 && n != 0; i++) begin
      @(negedge clk);
      n = (d == 0) ? q0.size() : q1.size();
    end
    if (n != 0) check_eq("drain_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_op[d] = 3'd0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_pc[d] = 32'h0; last_acc[d] = 0; prev_hold[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", 32'(req_ready[d]), 32'd0);
      check_eq("rst_valid", 32'(resp_valid[d]), 32'd0);
      check_eq("rst_exc", 32'(resp_exc[d]), 32'd0);
    end
    reset0 = 1'b0;
    reset1 = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    check_eq("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    // LATENCY=1, base 0: lane stores, extending loads, faults.
    issue(0, OP_SW,  32'h10,   32'hDEADBEEF, 32'h0,        EXC_NONE,     1'b0);
    issue(0, OP_LW,  32'h10,   32'h0,        32'hDEADBEEF, EXC_NONE,     1'b0);
    issue(0, OP_SB,  32'h11,   32'h000000AA, 32'h0,        EXC_NONE,     1'b0);
    issue(0, OP_LB,  32'h11,   32'h0,        32'hFFFFFFAA, EXC_NONE,     1'b0);
    issue(0, OP_LBU, 32'h11,   32'h0,        32'h000000AA, EXC_NONE,     1'b0);
    issue(0, OP_LW,  32'h10,   32'h0,        32'hDEADAAEF, EXC_NONE,     1'b0);
    issue(0, OP_SH,  32'h12,   32'h00008001, 32'h0,        EXC_NONE,     1'b0);
    issue(0, OP_LH,  32'h12,   32'h0,        32'hFFFF8001, EXC_NONE,     1'b0);
    issue(0, OP_LHU, 32'h12,   32'h0,        32'h00008001, EXC_NONE,     1'b0);
    issue(0, OP_LB,  32'h13,   32'h0,        32'hFFFFFF80, EXC_NONE,     1'b0);
    issue(0, OP_LH,  32'h13,   32'h0,        32'h0,        EXC_MISALIGN, 1'b0);
    issue(0, OP_SW,  32'h12,   32'hFFFFFFFF, 32'h0,        EXC_MISALIGN, 1'b0);
    issue(0, OP_LW,  32'h10,   32'h0,        32'h8001AAEF, EXC_NONE,     1'b0);
    issue(0, OP_LW,  32'h3000, 32'h0,        32'h0,        EXC_RANGE,    1'b0);
    issue(0, OP_SW,  32'h3000, 32'h12345678, 32'h0,        EXC_RANGE,    1'b0);
    issue(0, OP_LW,  32'h2FFC, 32'h0,        32'h0,        EXC_NONE,     1'b0);
    issue(0, OP_LW,  32'h10,   32'h0,        32'h8001AAEF, EXC_NONE,     1'b0);
    drain(0);

    // LATENCY=4, base 0x1000: range edges, then back-to-back with req_valid held high.
    issue(1, OP_LW,  32'h0FFC, 32'h0,        32'h0,        EXC_RANGE,    1'b0);
    issue(1, OP_LW,  32'h4000, 32'h0,        32'h0,        EXC_RANGE,    1'b0);
    issue(1, OP_SW,  32'h1004, 32'h11223344, 32'h0,        EXC_NONE,     1'b1);
    issue(1, OP_LW,  32'h1004, 32'h0,        32'h11223344, EXC_NONE,     1'b1);
    issue(1, OP_LBU, 32'h1007, 32'h0,        32'h00000011, EXC_NONE,     1'b1);
    issue(1, OP_LH,  32'h1006, 32'h0,        32'h00001122, EXC_NONE,     1'b1);
    issue(1, OP_LB,  32'h1004, 32'h0,        32'h00000044, EXC_NONE,     1'b1);
    drain(1);

    // Reset two cycles into an outstanding load: no response, memory cleared.
    issue(1, OP_SW,  32'h1020, 32'hCAFEF00D, 32'h0,        EXC_NONE,     1'b0);
    drain(1);
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = OP_LW; req_addr[1] = 32'h1020;
    check_eq("mid_accept_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset1 = 1'b1;
    #1 check_eq("ready_in_reset", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    reset1 = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("ready_post_reset", 32'(req_ready[1]), 32'd1);
    issue(1, OP_LW,  32'h1020, 32'h0,        32'h0,        EXC_NONE,     1'b0);
    issue(1, OP_LW,  32'h1004, 32'h0,        32'h0,        EXC_NONE,     1'b0);
    drain(1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_pipe_mem.md
Name: dm_pipe_mem

Overview:
- Parametrised, multi-cycle successor to the single-cycle word data memory.
- Adds byte/halfword stores, sign/zero-extending loads, address range and alignment checking, and a configurable response latency behind a valid/ready request port.
- Sits in the MEM stage; the pipeline stalls while req_ready is low or a response is outstanding.

Parameters:
DEPTH, 3072, number of 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of word 0.
LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..8.
TRACE, 1, when 1, each committed store prints a trace line.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_op  in  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
req_addr  in  32  byte address
req_wdata  in  32  store data; low bits used for SH/SB
req_pc  in  32  PC of the issuing instruction, used for trace only
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_exc  out  2  00 ok, 01 misaligned, 10 out of range

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- Reset (synchronous):
  - All DEPTH words cleared to 0.
  - State goes to IDLE; counter cleared.
  - req_ready=0 during the reset cycle.
  - resp_valid=0, resp_rdata=0, resp_exc=00.
- FSM states: IDLE, WAIT.
  - req_ready = (state==IDLE) && !reset.
  - Accept = req_valid && req_ready, sampled at posedge.
  - On accept: capture op, addr, pc; set cnt=LATENCY-1; go to WAIT.
  - In WAIT: cnt decrements each cycle. When cnt==0, pulse resp_valid for one cycle and return to IDLE.
  - A new request may be accepted in the cycle after resp_valid, not in the same cycle.
  - Net behaviour: response appears exactly LATENCY cycles after the accept edge; throughput is one request per LATENCY+1 cycles.
- Checks, evaluated at accept:
  - Range: addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH gives exc=10. Range has priority over alignment.
  - Alignment: LW/SW require addr[1:0]==0; LH/LHU/SH require addr[0]==0; otherwise exc=01.
  - A faulting store never modifies memory and never prints.
- Stores:
  - Commit on the accept edge.
  - word index = (addr-BASE_ADDR)>>2.
  - Byte-enable: SW=1111; SH=0011<<addr[1]*2; SB=0001<<addr[1:0].
  - Data: req_wdata lane-replicated (byte x4 or half x2) and masked by the byte enables.
  - If TRACE=1, print "%d@%h: *%h <= %h" with time, pc, word-aligned address, and the full merged word after the write.
- Loads:
  - Word read on the accept edge into a holding register; it is immune to later stores.
  - Lane selected by addr[1:0]; LH/LB sign-extend, LHU/LBU zero-extend.
  - resp_rdata is valid only while resp_valid=1 and is held 0 otherwise.
- Reset mid-WAIT: the outstanding request is dropped and no resp_valid is produced. A store already committed is erased by the memory clear.
- req_valid while req_ready=0 is ignored; the requester must hold its request.
- req_* inputs are don't-care while req_valid=0.

Decomposition:
- Package dm_pkg:
  - op encodings (OP_LW..OP_SB) and exc codes (EXC_NONE, EXC_MISALIGN, EXC_RANGE);
  - state enum {IDLE, WAIT};
  - function is_store(op).
- Sub-module dm_lane_align, purely combinational:
  - inputs op, addr[1:0], wdata, rword;
  - outputs byte_en[3:0], wdata_rep[31:0], load_ext[31:0], misaligned.
- Top module holds the FSM, latency counter, range check, memory array and trace.

Test Plan:
- LATENCY=1: SW 0x0000_0010 <= 0xDEADBEEF, then LW 0x10 -> resp_valid one cycle after accept, rdata=0xDEADBEEF, exc=00, and a single trace line.
- SB 0x11 <= 0x000000AA over 0xDEADBEEF, then LB 0x11 -> rdata=0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LW 0x10 -> 0xDEADAAEF.
- SH 0x12 <= 0x8001, then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001. LH 0x13 -> exc=01, rdata=0; SW 0x12 -> exc=01 and memory unchanged.
- LW at 4*DEPTH (0x3000) -> exc=10, no write, no trace; BASE_ADDR=0x1000 with LW 0x0FFC -> exc=10.
- LATENCY=4:
  - req_valid held high continuously -> req_ready low for 4 cycles after each accept;
  - resp_valid exactly 4 cycles after accept; successive accepts 5 cycles apart.
- Assert reset 2 cycles into a LATENCY=4 LW -> no resp_valid; req_ready=0 during reset, then 1; a subsequent LW of any previously written address returns 0.
